// File: rtl/lc3b_write_buffer_pkg.sv
// Shared types and default widths for the L1-eviction write-back buffer.
package lc3b_write_buffer_pkg;

  localparam int LC3B_WB_ADR_W = 12;   // tracks lc3b_wb_adr
  localparam int LC3B_LINE_W   = 128;  // tracks lc3b_line

  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_DRAIN = 1'b1
  } lc3b_wbuf_state;

endpackage

// File: rtl/lc3b_wbuf_cam.sv
// DEPTH-way address CAM; walks entries oldest to youngest from the head so the
// youngest matching entry wins. Optionally ignores the head entry.
module lc3b_wbuf_cam
  import lc3b_write_buffer_pkg::*;
#(
  parameter int ADDR_W = LC3B_WB_ADR_W,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             i_valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] i_addr,
  input  logic [PTR_W-1:0]             i_head,
  input  logic [ADDR_W-1:0]            i_key,
  input  logic                         i_skip_head,
  output logic                         o_hit,
  output logic [PTR_W-1:0]             o_idx
);

  always_comb begin
    logic [PTR_W-1:0] w_slot;
    o_hit  = 1'b0;
    o_idx  = '0;
    w_slot = i_head;
    for (int k = 0; k < DEPTH; k++) begin
      if (i_valid[w_slot] && !(i_skip_head && (w_slot == i_head)) &&
          (i_addr[w_slot] == i_key)) begin
        o_hit = 1'b1;
        o_idx = w_slot;
      end
      w_slot = (w_slot == PTR_W'(DEPTH - 1)) ? '0 : w_slot + 1'b1;
    end
  end

endmodule

// File: rtl/lc3b_write_buffer.sv
// N-entry write-back buffer between L1 evictions and L2/pmem: one-cycle accept,
// oldest-first drain on watermark/idle/flush, in-place coalescing, lookup port.
module lc3b_write_buffer
  import lc3b_write_buffer_pkg::*;
#(
  parameter int ADDR_W       = LC3B_WB_ADR_W,
  parameter int LINE_W       = LC3B_LINE_W,
  parameter int DEPTH        = 4,
  parameter int DRAIN_THRESH = 2,
  parameter int IDLE_TIMEOUT = 8,
  parameter bit COALESCE     = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_write,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [LINE_W-1:0]          in_wdata,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          lk_addr,
  output logic                       lk_hit,
  output logic [LINE_W-1:0]          lk_rdata,
  input  logic                       flush,
  output logic                       flush_done,
  output logic                       pmem_write,
  output logic [ADDR_W-1:0]          pmem_address,
  output logic [LINE_W-1:0]          pmem_wdata,
  input  logic                       pmem_resp,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int IDLE_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  lc3b_wbuf_state               r_state, w_state_next;
  logic [DEPTH-1:0]             r_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
  logic [DEPTH-1:0][LINE_W-1:0] r_data;
  logic [PTR_W-1:0]             r_head, r_tail;
  logic [CNT_W-1:0]             r_count, w_count_next;
  logic [IDLE_W-1:0]            r_idle_cnt;
  logic                         w_draining, w_idle_hit;
  logic                         w_coal_match, w_coal_hit, w_full;
  logic                         w_push, w_alloc, w_pop, w_lk_match;
  logic [PTR_W-1:0]             w_coal_idx, w_lk_idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic start_ok(input logic [CNT_W-1:0] n, input logic fl,
                                    input logic idle_hit);
    return (n != '0) && ((n >= CNT_W'(DRAIN_THRESH)) || fl || idle_hit);
  endfunction

  // The head is excluded while draining: its bytes are already on the pmem bus.
  lc3b_wbuf_cam #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_coal_cam (
    .i_valid     (r_valid),
    .i_addr      (r_addr),
    .i_head      (r_head),
    .i_key       (in_addr),
    .i_skip_head (w_draining),
    .o_hit       (w_coal_match),
    .o_idx       (w_coal_idx)
  );

  lc3b_wbuf_cam #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_lk_cam (
    .i_valid     (r_valid),
    .i_addr      (r_addr),
    .i_head      (r_head),
    .i_key       (lk_addr),
    .i_skip_head (1'b0),
    .o_hit       (w_lk_match),
    .o_idx       (w_lk_idx)
  );

  assign w_coal_hit   = COALESCE & w_coal_match;
  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign in_ready     = !w_full || w_coal_hit;
  assign w_push       = in_write && in_ready;
  assign w_alloc      = w_push && !w_coal_hit;
  assign w_pop        = w_draining && pmem_resp;
  assign w_count_next = r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
  assign w_idle_hit   = (r_idle_cnt == IDLE_W'(IDLE_TIMEOUT));

  assign lk_hit       = w_lk_match;
  assign lk_rdata     = w_lk_match ? r_data[w_lk_idx] : '0;
  assign pmem_address = r_addr[r_head];
  assign pmem_wdata   = r_data[r_head];
  assign count        = r_count;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= WB_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    w_state_next = r_state;
    case (r_state)
      WB_IDLE:  if (start_ok(r_count, flush, w_idle_hit)) w_state_next = WB_DRAIN;
      WB_DRAIN: if (w_pop)
                  w_state_next = start_ok(w_count_next, flush, w_idle_hit) ? WB_DRAIN : WB_IDLE;
    endcase
  end

  always_comb begin
    w_draining = (r_state == WB_DRAIN);
    pmem_write = w_draining;
    flush_done = flush && (r_count == '0) && (r_state == WB_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_idle_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= ptr_inc(r_head);
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= ptr_inc(r_tail);
      end
      r_count <= w_count_next;
      if (w_push || (r_count == '0)) r_idle_cnt <= '0;
      else if (!w_draining && !w_idle_hit) r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  // NOTE: line storage has no reset; r_valid alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_addr[r_tail] <= in_addr;
      r_data[r_tail] <= in_wdata;
    end else if (w_push && w_coal_hit) begin
      r_data[w_coal_idx] <= in_wdata;
    end
  end

endmodule
